// File: rtl/vga_timing_checker_pkg.sv
// rtl/vga_timing_checker_pkg.sv - shared FSM encoding and default 640x480 timing constants
package vga_timing_checker_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int DEF_HTOTAL = 800;
  localparam int DEF_HPULSE = 96;
  localparam int DEF_VTOTAL = 521;
  localparam int DEF_VPULSE = 2;

  localparam logic [10:0] CNT_MAX = 11'd2047;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/vga_edge_meas.sv
// rtl/vga_edge_meas.sv - active-low sync edge detector with saturating period/width counter
module vga_edge_meas
  import vga_timing_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        inc,
  input  logic [10:0] load_val,
  output logic        fall,
  output logic        rise,
  output logic [10:0] cnt,
  output logic [10:0] period,
  output logic [10:0] width
);

  logic sync_q;

  assign fall = sync_q & ~sync;
  assign rise = ~sync_q & sync;

  // period and width capture the count before this cycle's update
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      cnt    <= 11'd0;
      period <= 11'd0;
      width  <= 11'd0;
    end else begin
      sync_q <= sync;
      if (fall) begin
        cnt    <= load_val;
        period <= cnt;
      end else if (inc) begin
        cnt <= sat_inc(cnt);
      end
      if (rise) begin
        width <= cnt;
      end
    end
  end

endmodule

// File: rtl/vga_timing_checker.sv
// rtl/vga_timing_checker.sv - measures VGA sync timing, locks after consecutive good frames
module vga_timing_checker
  import vga_timing_checker_pkg::*;
#(
  parameter int EXP_HTOTAL  = DEF_HTOTAL,
  parameter int EXP_HPULSE  = DEF_HPULSE,
  parameter int EXP_VTOTAL  = DEF_VTOTAL,
  parameter int EXP_VPULSE  = DEF_VPULSE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic        err_clr,
  output logic        locked,
  output logic [10:0] htotal_meas,
  output logic [10:0] hpulse_meas,
  output logic [10:0] vtotal_meas,
  output logic [10:0] vpulse_meas,
  output logic [15:0] frame_cnt,
  output logic        frame_tick,
  output logic        err_timing,
  output logic        err_blank,
  output logic        err_lock_lost
);

  localparam logic [10:0] HT_C   = 11'(EXP_HTOTAL);
  localparam logic [10:0] HP_C   = 11'(EXP_HPULSE);
  localparam logic [10:0] VT_C   = 11'(EXP_VTOTAL);
  localparam logic [10:0] VP_C   = 11'(EXP_VPULSE);
  localparam logic [7:0]  LOCK_C = 8'(LOCK_FRAMES);

  logic        hfall, hrise, vfall, vrise;
  logic [10:0] hcnt, lcnt;
  logic [1:0]  state, state_next;
  logic [7:0]  good_cnt, good_next, good_inc;
  logic        hvalid, line_bad;
  logic        lost, evaluate, h_bad_now, frame_good, blank_viol;

  vga_edge_meas u_hmeas (
    .clk      (clk),
    .rst      (rst),
    .sync     (hsync),
    .inc      (1'b1),
    .load_val (11'd1),
    .fall     (hfall),
    .rise     (hrise),
    .cnt      (hcnt),
    .period   (htotal_meas),
    .width    (hpulse_meas)
  );

  vga_edge_meas u_vmeas (
    .clk      (clk),
    .rst      (rst),
    .sync     (vsync),
    .inc      (hfall),
    .load_val ({10'd0, hfall}),
    .fall     (vfall),
    .rise     (vrise),
    .cnt      (lcnt),
    .period   (vtotal_meas),
    .width    (vpulse_meas)
  );

  // hsync loss is flagged once, on the cycle the line counter first saturates
  assign lost       = (hcnt == 11'd2046) && !hfall;
  assign evaluate   = vfall && !lost && (state != ST_SEARCH);
  assign h_bad_now  = hvalid && ((hfall && hcnt != HT_C) || (hrise && hcnt != HP_C));
  assign frame_good = (lcnt == VT_C) && (vpulse_meas == VP_C) && !(line_bad || h_bad_now);
  assign blank_viol = (!hsync || !vsync) && ({red, green, blue} != 12'd0);
  assign good_inc   = good_cnt + 8'd1;

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    if (lost) begin
      state_next = ST_SEARCH;
      good_next  = 8'd0;
    end else if (vfall) begin
      case (state)
        ST_SEARCH: state_next = ST_CHECK;
        ST_CHECK: begin
          if (frame_good) begin
            good_next = good_inc;
            if (good_inc >= LOCK_C) state_next = ST_LOCKED;
          end else begin
            good_next = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (!frame_good) begin
            state_next = ST_CHECK;
            good_next  = 8'd0;
          end
        end
        default: begin
          state_next = ST_SEARCH;
          good_next  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_SEARCH;
      good_cnt      <= 8'd0;
      hvalid        <= 1'b0;
      line_bad      <= 1'b0;
      locked        <= 1'b0;
      frame_tick    <= 1'b0;
      frame_cnt     <= 16'd0;
      err_timing    <= 1'b0;
      err_blank     <= 1'b0;
      err_lock_lost <= 1'b0;
    end else begin
      state      <= state_next;
      good_cnt   <= good_next;
      locked     <= (state_next == ST_LOCKED);
      frame_tick <= evaluate;
      if (evaluate) frame_cnt <= frame_cnt + 16'd1;

      if (lost)       hvalid <= 1'b0;
      else if (hfall) hvalid <= 1'b1;

      if (vfall)          line_bad <= 1'b0;
      else if (h_bad_now) line_bad <= 1'b1;

      // a fresh error in the clearing cycle keeps its flag set
      err_timing    <= (evaluate && !frame_good) || (err_timing && !err_clr);
      err_lock_lost <= (evaluate && !frame_good && state == ST_LOCKED) ||
                       (err_lock_lost && !err_clr);
      err_blank     <= blank_viol || (err_blank && !err_clr);
    end
  end

endmodule

// File: tb/tb_vga_timing_checker.sv
// tb/tb_vga_timing_checker.sv - scoreboard bench: scaled-down timing stream, frame_tick monitor
module tb_vga_timing_checker;

  localparam int HT = 40;
  localparam int HP = 6;
  localparam int VT = 12;
  localparam int VP = 2;

  logic        clk, rst, hsync, vsync, err_clr;
  logic [3:0]  red, green, blue;
  logic        locked, frame_tick, err_timing, err_blank, err_lock_lost;
  logic [10:0] htotal_meas, hpulse_meas, vtotal_meas, vpulse_meas;
  logic [15:0] frame_cnt;

  typedef struct {
    logic        lk;
    logic        et;
    logic        ell;
    logic        eb;
    logic [15:0] fc;
    logic [10:0] vp;
  } exp_t;

  exp_t exq[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   n_ticks = 0;

  vga_timing_checker #(
    .EXP_HTOTAL(HT), .EXP_HPULSE(HP), .EXP_VTOTAL(VT), .EXP_VPULSE(VP), .LOCK_FRAMES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hsync         (hsync),
    .vsync         (vsync),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .err_clr       (err_clr),
    .locked        (locked),
    .htotal_meas   (htotal_meas),
    .hpulse_meas   (hpulse_meas),
    .vtotal_meas   (vtotal_meas),
    .vpulse_meas   (vpulse_meas),
    .frame_cnt     (frame_cnt),
    .frame_tick    (frame_tick),
    .err_timing    (err_timing),
    .err_blank     (err_blank),
    .err_lock_lost (err_lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic lk, et, ell, eb, input int fc, input int vp);
    exp_t x;
    x.lk = lk; x.et = et; x.ell = ell; x.eb = eb;
    x.fc = 16'(fc); x.vp = 11'(vp);
    exq.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_htotal"}, htotal_meas, 0);
    chk({tag, "_hpulse"}, hpulse_meas, 0);
    chk({tag, "_vtotal"}, vtotal_meas, 0);
    chk({tag, "_vpulse"}, vpulse_meas, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_frame_tick"}, frame_tick, 0);
    chk({tag, "_err_timing"}, err_timing, 0);
    chk({tag, "_err_blank"}, err_blank, 0);
    chk({tag, "_err_lock_lost"}, err_lock_lost, 0);
  endtask

  // one frame; negative line numbers disable the corresponding injection
  task automatic gen_frame(input int vp_lines, stretch_line, blank_line, clr_line,
                           both_line, rst_line);
    for (int v = 0; v < VT; v++) begin
      int len;
      len = HT + ((v == stretch_line) ? 1 : 0);
      for (int h = 0; h < len; h++) begin
        hsync = (h >= HP);
        vsync = (v >= vp_lines);
        red = 4'h0; err_clr = 1'b0; rst = 1'b0;
        if (v == blank_line && h == 1) red = 4'hF;
        if (v == clr_line && h == HP + 3) err_clr = 1'b1;
        if (v == both_line && h == 1) begin red = 4'hF; err_clr = 1'b1; end
        if (v == rst_line && h == 10) rst = 1'b1;
        @(posedge clk); #1;
        if (v == blank_line && h == 1) chk("blank_set", err_blank, 1);
        if (v == clr_line && h == HP + 3) begin
          chk("clr_err_blank", err_blank, 0);
          chk("clr_err_timing", err_timing, 0);
          chk("clr_err_lock_lost", err_lock_lost, 0);
        end
        if (v == both_line && h == 1) chk("clr_vs_new_blank", err_blank, 1);
        if (v == rst_line && h == 10) check_zero("midrst");
      end
    end
    red = 4'h0; err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic nominal();
    gen_frame(VP, -1, -1, -1, -1, -1);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_tick) begin
      if (exq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick actual=1 required=0");
      end else begin
        e = exq.pop_front();
        n_ticks++;
        chk("tick_locked", locked, e.lk);
        chk("tick_err_timing", err_timing, e.et);
        chk("tick_err_lock_lost", err_lock_lost, e.ell);
        chk("tick_err_blank", err_blank, e.eb);
        chk("tick_frame_cnt", frame_cnt, e.fc);
        chk("tick_htotal", htotal_meas, HT);
        chk("tick_hpulse", hpulse_meas, HP);
        chk("tick_vtotal", vtotal_meas, VT);
        chk("tick_vpulse", vpulse_meas, e.vp);
      end
    end
  end

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1;
    red = 4'h0; green = 4'h0; blue = 4'h0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    nominal();                             push(0, 0, 0, 0, 1, VP);
    nominal();                             push(1, 0, 0, 0, 2, VP);
    gen_frame(VP, 5, -1, -1, -1, -1);      push(0, 1, 1, 0, 3, VP);
    nominal();                             push(0, 1, 1, 0, 4, VP);
    nominal();                             push(1, 1, 1, 0, 5, VP);
    gen_frame(VP, -1, 3, 5, 7, -1);        push(1, 0, 0, 1, 6, VP);
    gen_frame(3, -1, -1, -1, -1, -1);      push(0, 1, 1, 1, 7, 3);
    nominal();                             push(0, 1, 1, 1, 8, VP);
    nominal();                             push(1, 1, 1, 1, 9, VP);
    nominal();

    hsync = 1'b1; vsync = 1'b1;
    repeat (2100) @(posedge clk);
    #1;
    chk("stuck_locked", locked, 0);
    chk("stuck_frame_cnt", frame_cnt, 9);

    nominal();                             push(0, 1, 1, 1, 10, VP);
    nominal();                             push(1, 1, 1, 1, 11, VP);
    gen_frame(VP, -1, -1, -1, -1, 4);
    nominal();                             push(0, 0, 0, 0, 1, VP);
    nominal();                             push(1, 0, 0, 0, 2, VP);
    nominal();
    repeat (3) @(posedge clk);
    #1;

    chk("queue_empty", exq.size(), 0);
    chk("tick_count", n_ticks, 13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
